// File: rtl/hid_keycode_extract.sv
// Reduces an 8-byte USB HID boot-protocol keyboard report to one keycode plus modifiers.
// Optional build macro HID_WASD_FILTER_EN limits selection to the W/A/S/D keycodes.
module hid_keycode_extract #(
    parameter int REPORT_BYTES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_sop,
    output logic       rx_ready,
    output logic [7:0] keycode,
    output logic [7:0] modifiers,
    output logic       key_update,
    output logic       report_err
);

    localparam int CNT_W = $clog2(REPORT_BYTES + 1);
    localparam int IDX_W = $clog2(REPORT_BYTES);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPORT_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REPORT_BYTES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       report_q [REPORT_BYTES];
    logic [7:0]       report_d [REPORT_BYTES];

    // Evaluation stage: results latched on leaving COMMIT, applied one edge later.
    logic             commit_q, commit_d;
    logic             rollover_q, rollover_d;
    logic [7:0]       sel_q, sel_d;
    logic [7:0]       mod_q, mod_d;

    logic [7:0]       keycode_q, keycode_d;
    logic [7:0]       modifiers_q, modifiers_d;
    logic             key_update_q, key_update_d;
    logic             report_err_q, report_err_d;

    logic             xfer;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       sel_key;
    logic             sel_found;

    logic [REPORT_BYTES-1:2] key_elig;
    logic [REPORT_BYTES-1:2] key_roll;

    assign rx_ready = ~Reset & (state_q != ST_COMMIT);
    assign xfer     = rx_valid & rx_ready;
    assign wr_idx   = cnt_q[IDX_W-1:0];

    // Per key-slot classification of the shadow report.
    genvar gi;
    generate
        for (gi = 2; gi < REPORT_BYTES; gi++) begin : g_key
            assign key_roll[gi] = (report_q[gi] == 8'h01);
`ifdef HID_WASD_FILTER_EN
            assign key_elig[gi] = (report_q[gi] == 8'h1A) || (report_q[gi] == 8'h16) ||
                                  (report_q[gi] == 8'h07) || (report_q[gi] == 8'h04);
`else
            assign key_elig[gi] = (report_q[gi] > 8'h03);
`endif
        end
    endgenerate

    // Lowest-index eligible key wins.
    always_comb begin
        sel_key   = 8'h00;
        sel_found = 1'b0;
        for (int i = 2; i < REPORT_BYTES; i++) begin
            if (!sel_found && key_elig[i]) begin
                sel_key   = report_q[i];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        report_d     = report_q;
        commit_d     = 1'b0;
        rollover_d   = rollover_q;
        sel_d        = sel_q;
        mod_d        = mod_q;
        keycode_d    = keycode_q;
        modifiers_d  = modifiers_q;
        key_update_d = 1'b0;
        report_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (xfer && rx_sop) begin
                    report_d[0] = rx_data;
                    cnt_d       = CNT_ONE;
                    state_d     = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (xfer) begin
                    timer_d = '0;
                    if (rx_sop) begin
                        // Short report: drop it and restart on this byte.
                        report_err_d = 1'b1;
                        report_d[0]  = rx_data;
                        cnt_d        = CNT_ONE;
                    end else begin
                        report_d[wr_idx] = rx_data;
                        if (cnt_q >= CNT_LAST) begin
                            cnt_d   = CNT_FULL;
                            state_d = ST_COMMIT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    report_err_d = 1'b1;
                    timer_d      = '0;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            ST_COMMIT: begin
                commit_d   = 1'b1;
                rollover_d = |key_roll;
                sel_d      = sel_key;
                mod_d      = report_q[0];
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Never overlaps a framing error: the FSM is in IDLE on this cycle.
        if (commit_q) begin
            if (rollover_q) begin
                report_err_d = 1'b1;
            end else begin
                key_update_d = 1'b1;
                keycode_d    = sel_q;
                modifiers_d  = mod_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            commit_q     <= 1'b0;
            rollover_q   <= 1'b0;
            sel_q        <= 8'h00;
            mod_q        <= 8'h00;
            keycode_q    <= 8'h00;
            modifiers_q  <= 8'h00;
            key_update_q <= 1'b0;
            report_err_q <= 1'b0;
            for (int i = 0; i < REPORT_BYTES; i++) begin
                report_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            commit_q     <= commit_d;
            rollover_q   <= rollover_d;
            sel_q        <= sel_d;
            mod_q        <= mod_d;
            keycode_q    <= keycode_d;
            modifiers_q  <= modifiers_d;
            key_update_q <= key_update_d;
            report_err_q <= report_err_d;
            report_q     <= report_d;
        end
    end

    assign keycode    = keycode_q;
    assign modifiers  = modifiers_q;
    assign key_update = key_update_q;
    assign report_err = report_err_q;

endmodule

// File: tb/tb_hid_keycode_extract.sv
// Randomised scoreboard bench for hid_keycode_extract; reference model works on whole reports.
module tb_hid_keycode_extract;

    localparam int T = 1024;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_sop = 1'b0;
    logic       rx_ready;
    logic [7:0] keycode;
    logic [7:0] modifiers;
    logic       key_update;
    logic       report_err;

    hid_keycode_extract #(.REPORT_BYTES(8), .TIMEOUT_CYCLES(T)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_ready   (rx_ready),
        .keycode    (keycode),
        .modifiers  (modifiers),
        .key_update (key_update),
        .report_err (report_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_key;
        logic [7:0] key;
        logic [7:0] mod;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    // Reference model state: bytes of the report being gathered.
    bit         in_rep = 1'b0;
    logic [7:0] cur[$];
    int         last_acc = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic bit eligible(logic [7:0] k);
`ifdef HID_WASD_FILTER_EN
        return (k == 8'h1A || k == 8'h16 || k == 8'h07 || k == 8'h04);
`else
        return (k >= 8'h04);
`endif
    endfunction

    function automatic void push_ev(bit is_key, logic [7:0] k, logic [7:0] m, int c);
        ev_t e;
        e.is_key = is_key;
        e.key    = k;
        e.mod    = m;
        e.cyc    = c;
        exp_q.push_back(e);
    endfunction

    function automatic void evaluate(int e);
        bit         roll = 1'b0;
        bit         found = 1'b0;
        logic [7:0] sel = 8'h00;
        for (int i = 2; i < 8; i++) begin
            if (cur[i] == 8'h01) roll = 1'b1;
            if (!found && eligible(cur[i])) begin
                sel   = cur[i];
                found = 1'b1;
            end
        end
        if (roll) push_ev(1'b0, 8'h00, 8'h00, e + 2);
        else      push_ev(1'b1, sel, cur[0], e + 2);
    endfunction

    // One clock edge e of the model; acc says whether a byte was accepted there.
    function automatic void model_edge(bit acc, logic [7:0] d, bit s, int e);
        if (in_rep && !acc && e == last_acc + T) begin
            push_ev(1'b0, 8'h00, 8'h00, e);
            in_rep = 1'b0;
            cur.delete();
        end
        if (acc) begin
            if (in_rep && s) push_ev(1'b0, 8'h00, 8'h00, e);
            if (s) begin
                cur.delete();
                cur.push_back(d);
                in_rep = 1'b1;
            end else if (in_rep) begin
                cur.push_back(d);
            end
            if (in_rep) begin
                last_acc = e;
                if (cur.size() == 8) begin
                    evaluate(e);
                    in_rep = 1'b0;
                    cur.delete();
                end
            end
        end
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input bit s, output bit acc);
        @(negedge Clk);
        Reset    = 1'b0;
        rx_valid = v;
        rx_data  = d;
        rx_sop   = s;
        #1;
        acc = v && rx_ready;
        model_edge(acc, d, s, cyc + 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s);
        bit acc;
        int n = 0;
        do begin
            step(1'b1, d, s, acc);
            n++;
        end while (!acc && n < 16);
        chk("byte_accepted", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic send_report(input logic [7:0] b[8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(3, 0) == 0) idle(1);
            send_byte(b[i], i == 0);
        end
    endtask

    task automatic do_reset(input int n);
        ev_t keep[$];
        repeat (n) begin
            @(negedge Clk);
            Reset    = 1'b1;
            rx_valid = 1'b0;
            rx_sop   = 1'b0;
            #1;
            chk("rx_ready_in_reset", int'(rx_ready), 0);
            in_rep = 1'b0;
            cur.delete();
            keep.delete();
            foreach (exp_q[i]) if (exp_q[i].cyc < cyc + 1) keep.push_back(exp_q[i]);
            exp_q = keep;
        end
    endtask

    // Monitor: pops one expectation per output pulse.
    initial begin
        ev_t e;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: no pulse seen, expected %s at cycle %0d (now %0d)",
                         exp_q[0].is_key ? "key_update" : "report_err", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (key_update || report_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: key_update=%0b report_err=%0b, expected none (cycle %0d)",
                             key_update, report_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("event cycle=%0d kind=%s keycode=%02h modifiers=%02h",
                             cyc, key_update ? "key" : "err", keycode, modifiers);
                    chk("event_cycle", cyc, e.cyc);
                    chk("key_update", int'(key_update), int'(e.is_key));
                    chk("report_err", int'(report_err), int'(!e.is_key));
                    if (e.is_key) begin
                        chk("event_keycode", keycode, e.key);
                        chk("event_modifiers", modifiers, e.mod);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] r[8];
        logic [7:0] pool[10];
        pool = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'hE0, 8'h00};

        do_reset(3);
        idle(2);
        chk("reset_keycode", keycode, 8'h00);
        chk("reset_modifiers", modifiers, 8'h00);
        chk("reset_key_update", int'(key_update), 0);
        chk("reset_report_err", int'(report_err), 0);
        chk("idle_rx_ready", int'(rx_ready), 1);

        // Basic report, back to back.
        r = '{8'h00, 8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(r, 1'b0);
        idle(4);
        chk("t1_keycode", keycode, 8'h1A);
        chk("t1_modifiers", modifiers, 8'h00);

        // Rollover keeps previous outputs.
        r = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_report(r, 1'b0);
        idle(4);
        chk("rollover_keycode_held", keycode, 8'h1A);

        r = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(r, 1'b0);
        idle(4);
        chk("t2_keycode", keycode, 8'h00);
        chk("t2_modifiers", modifiers, 8'h02);

        // Timeout after three bytes.
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h1A, 1'b0);
        idle(T + 2);
        chk("timeout_idle_ready", int'(rx_ready), 1);
        r = '{8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(r, 1'b0);
        idle(4);
        chk("t4_keycode", keycode, 8'h16);

        // Gap of exactly TIMEOUT_CYCLES between bytes is still accepted.
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(T - 1);
        send_byte(8'h04, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        idle(4);
        chk("gap_limit_keycode", keycode, 8'h04);
        chk("gap_limit_modifiers", modifiers, 8'h03);

        // One cycle longer times out; the rest of the bytes are dropped in IDLE.
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h1A, 1'b0);
        idle(T);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
        idle(4);
        chk("gap_over_keycode_held", keycode, 8'h04);

        // Resync on early sop.
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h1A, 1'b0);
        send_byte(8'h00, 1'b0);
        r = '{8'h00, 8'h00, 8'h2C, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(r, 1'b0);
        idle(4);
`ifdef HID_WASD_FILTER_EN
        chk("t5_keycode", keycode, 8'h07);
`else
        chk("t5_keycode", keycode, 8'h2C);
`endif

        // Reset mid-report.
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        do_reset(1);
        idle(3);
        chk("t6_reset_keycode", keycode, 8'h00);
        chk("t6_reset_modifiers", modifiers, 8'h00);
        r = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(r, 1'b0);
        idle(4);
        chk("t6_keycode", keycode, 8'h04);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(9, 0) == 0) send_byte(8'($urandom), 1'b0);
            if ($urandom_range(9, 0) == 0) begin
                int k = $urandom_range(6, 1);
                send_byte(8'($urandom), 1'b1);
                for (int i = 1; i < k; i++) send_byte(8'($urandom), 1'b0);
            end
            r[0] = 8'($urandom);
            r[1] = 8'($urandom);
            for (int i = 2; i < 8; i++)
                r[i] = ($urandom_range(1, 0) == 0) ? 8'h00 : pool[$urandom_range(9, 0)];
            send_report(r, 1'b1);
            idle($urandom_range(2, 0));
        end

        idle(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
